uart_flow_tx: RTL and testbench
===============================

Name: uart_flow_tx

Overview:
- Buffered UART transmitter for the far end of our flow-controlled serial link.
- Accepts bytes from a local producer into an internal FIFO and serialises them as 8-bit frames, LSB first.
- Honours the peer's RTS, which arrives on this block's cts input: high = peer can accept data.
- Optional parity and configurable stop bits, so it can drive our existing receiver or third-party equipment.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line bit rate. BIT_DIV = CLK_FREQ/BAUD_RATE (integer divide) is the number of clk cycles per bit.
- FIFO_DEPTH, 16, byte FIFO depth. Power of two, at least 2.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, 1 or 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  push wr_data into the FIFO.
- wr_data  in  8  byte to transmit.
- full  out  1  FIFO full; writes are rejected while high.
- empty  out  1  FIFO empty.
- level  out  $clog2(FIFO_DEPTH)+1  number of bytes in the FIFO.
- overflow  out  1  one-cycle pulse when a write is rejected.
- cts  in  1  asynchronous clear-to-send from the peer, active high.
- tx  out  1  serial line, idles high.
- busy  out  1  high while a frame is on the line (state != IDLE).

Behaviour:
- Reset values: tx=1, busy=0, full=0, empty=1, level=0, overflow=0. FIFO pointers cleared; state=IDLE.
- Reset mid-frame: the frame is abandoned, tx=1 from the next cycle, and the FIFO contents are discarded.
- Clocking: single clock domain. All outputs are registered.
- cts: passes through a 2-flop synchroniser (cts_s) before use.
- Write rule:
  - wr_en && !full pushes wr_data.
  - wr_en && full drops the byte; overflow=1 for the following cycle only.
  - full is the registered flag. A write in the same cycle as a pop while full is still rejected.
- Pop rule: the FSM pops the head byte in the same cycle it leaves IDLE.
- Simultaneous push and pop when not full/empty: level is unchanged.
- A single bit counter, bit_cnt, counts BIT_DIV-1 down to 0. It is reloaded at every state entry and at every bit boundary.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if !empty && cts_s, load the shift register with the head byte, set tx=0, and go to START.
  - START: hold tx=0 for BIT_DIV cycles, then go to DATA with tx=bit0.
  - DATA: each bit is held BIT_DIV cycles, 8 bits LSB first, tracked by a 3-bit index. After bit7: go to PARITY if PARITY!=0, otherwise go to STOP.
  - PARITY: tx = ^data (even) or ~^data (odd) for BIT_DIV cycles, then go to STOP.
  - STOP: tx=1 for STOP_BITS*BIT_DIV cycles, then go to IDLE.
- Frame length: (1+8+P+STOP_BITS)*BIT_DIV cycles, where P=1 if parity is enabled, else 0. Consecutive frames are separated by exactly 1 extra idle-high cycle (the IDLE state).
- Latency: with cts_s already high and the FIFO empty, wr_en sampled at edge k drives tx low from edge k+1.
- CTS semantics:
  - cts_s is evaluated only in IDLE.
  - Deasserting cts mid-frame never truncates that frame; the next frame is held until cts_s=1.
  - There is a 2-cycle synchroniser delay on assertion and on deassertion.
- Data wrap: FIFO pointers wrap modulo FIFO_DEPTH. level saturates at FIFO_DEPTH, where full=1.

Decomposition:
- Package uart_pkg holds:
  - the parity encoding constants (PAR_NONE/PAR_EVEN/PAR_ODD);
  - the tx state encoding;
  - a bit_div(freq, baud) constant function.
- Sub-module uart_byte_fifo: synchronous FIFO with wr_en, wr_data, rd_en, rd_data (first-word-fall-through), full, empty, level, and the overflow pulse.
- Serialiser FSM, bit counter and CTS synchroniser stay in uart_flow_tx.

Test Plan:
- All scenarios use CLK_FREQ=160, BAUD_RATE=10, so BIT_DIV=16.
- Basic frame: reset, cts=1, write 0x55 -> tx low 16 cycles, then 1,0,1,0,1,0,1,0 at 16 cycles each, then high 16 cycles; busy high exactly 160 cycles; tx falls the cycle after the write.
- Parity: PARITY=1, send 0x07 -> parity bit 1, frame 176 cycles. PARITY=2, send 0x07 -> parity bit 0. STOP_BITS=2 -> stop high for 32 cycles.
- Flow control hold: cts=0, write 0x11,0x22,0x33 -> tx stays 1, level=3. Raise cts -> after the 2-cycle sync, three frames in order, each followed by a 1-cycle idle gap; level reaches 0.
- CTS drop mid-frame: during the data bits of 0xA5, drop cts -> 0xA5 completes intact, the queued next byte is not started, tx stays 1 until cts returns high.
- Full/overflow: FIFO_DEPTH=4, cts=0, five writes -> full=1 after the 4th write; the 5th write gives a 1-cycle overflow pulse; level stays 4; the dropped byte is never transmitted.
- Reset mid-frame: assert rst during DATA bit 3 -> next cycle tx=1, busy=0, empty=1, level=0; no further frames are sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the flow-controlled UART transmitter: parity modes,
// serialiser state encoding and the clocks-per-bit helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Clock cycles per line bit; integer division truncates.
  function automatic int bit_div(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with first-word-fall-through read data and registered
// full/empty/level/overflow status.
module uart_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [LW-1:0] level_d;

  // Handshake: a byte is taken on any cycle with wr_en=1 and full=0 (full acts
  // as the inverted ready). wr_en=1 with full=1 drops the byte and raises
  // overflow for the next cycle; a same-cycle pop does not free the slot.
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    level_d = level + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level    <= level_d;
      full     <= (level_d == LW'(DEPTH));
      empty    <= (level_d == '0);
      overflow <= wr_en && full;
    end
  end

endmodule

// File: rtl/uart_flow_tx.sv
// Buffered UART transmitter: FIFO-fed 8-bit LSB-first frames with optional
// parity and 1/2 stop bits, gated between frames by the peer's CTS.
module uart_flow_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  input  logic                          cts,
  output logic                          tx,
  output logic                          busy
);

  localparam int BIT_DIV = bit_div(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W   = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(BIT_DIV - 1);
  localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

  logic             cts_meta;
  logic             cts_s;
  logic [7:0]       fifo_rd_data;
  logic             fifo_rd_en;

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       data_q, data_d;
  logic             bit_done;
  logic             par_bit;
  logic             tx_d;
  logic             busy_d;

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (fifo_rd_en),
    .rd_data  (fifo_rd_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cts_meta <= 1'b0;
      cts_s    <= 1'b0;
    end else begin
      cts_meta <= cts;
      cts_s    <= cts_meta;
    end
  end

  assign bit_done = (bit_cnt_q == '0);
  assign par_bit  = (PARITY == PAR_ODD) ? ~^data_q : ^data_q;

  // State register, including the registered line outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      tx        <= tx_d;
      busy      <= busy_d;
    end
  end

  // Next state. CTS is only consulted in IDLE, so a frame already on the line
  // always completes; bit_idx also counts stop bits once the data is out.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    data_d     = data_q;
    fifo_rd_en = 1'b0;
    if (state_q != ST_IDLE) begin
      bit_cnt_d = bit_done ? CNT_LOAD : bit_cnt_q - 1'b1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (!empty && cts_s) begin
          state_d    = ST_START;
          bit_cnt_d  = CNT_LOAD;
          bit_idx_d  = '0;
          data_d     = fifo_rd_data;
          fifo_rd_en = 1'b1;
        end
      end
      ST_START: begin
        if (bit_done) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_done) begin
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_done) begin
          if (bit_idx_q == LAST_STOP) state_d = ST_IDLE;
          else bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so tx/busy register in step with it.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_d[bit_idx_d];
      ST_PARITY: tx_d = par_bit;
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_uart_flow_tx.sv
// Bench for uart_flow_tx: four configurations (plain, even parity, odd parity
// with two stop bits, depth-4 FIFO) at 16 clocks per bit.
module tb_uart_flow_tx;

  localparam int N  = 4;
  localparam int BD = 16;
  localparam int NR = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en   [N];
  logic [7:0] wr_data [N];
  logic       cts     [N];
  logic       full    [N];
  logic       empty   [N];
  logic       overflow[N];
  logic       tx      [N];
  logic       busy    [N];
  logic [4:0] level0, level1, level2;
  logic [2:0] level3;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_flow_tx #(.CLK_FREQ(160), .BAUD_RATE(10), .FIFO_DEPTH(16), .PARITY(0), .STOP_BITS(1)) u_base (
    .clk(clk), .rst(rst), .wr_en(wr_en[0]), .wr_data(wr_data[0]), .full(full[0]), .empty(empty[0]),
    .level(level0), .overflow(overflow[0]), .cts(cts[0]), .tx(tx[0]), .busy(busy[0]));
  uart_flow_tx #(.CLK_FREQ(160), .BAUD_RATE(10), .FIFO_DEPTH(16), .PARITY(1), .STOP_BITS(1)) u_even (
    .clk(clk), .rst(rst), .wr_en(wr_en[1]), .wr_data(wr_data[1]), .full(full[1]), .empty(empty[1]),
    .level(level1), .overflow(overflow[1]), .cts(cts[1]), .tx(tx[1]), .busy(busy[1]));
  uart_flow_tx #(.CLK_FREQ(160), .BAUD_RATE(10), .FIFO_DEPTH(16), .PARITY(2), .STOP_BITS(2)) u_odd2 (
    .clk(clk), .rst(rst), .wr_en(wr_en[2]), .wr_data(wr_data[2]), .full(full[2]), .empty(empty[2]),
    .level(level2), .overflow(overflow[2]), .cts(cts[2]), .tx(tx[2]), .busy(busy[2]));
  uart_flow_tx #(.CLK_FREQ(160), .BAUD_RATE(10), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) u_small (
    .clk(clk), .rst(rst), .wr_en(wr_en[3]), .wr_data(wr_data[3]), .full(full[3]), .empty(empty[3]),
    .level(level3), .overflow(overflow[3]), .cts(cts[3]), .tx(tx[3]), .busy(busy[3]));

  function automatic int par_cfg(input int i);
    case (i)
      1:       return 1;
      2:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int stop_cfg(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  function automatic int lvl(input int i);
    case (i)
      0:       return int'(level0);
      1:       return int'(level1);
      2:       return int'(level2);
      default: return int'(level3);
    endcase
  endfunction

  function automatic int frame_len(input int i);
    return (1 + 8 + ((par_cfg(i) != 0) ? 1 : 0) + stop_cfg(i)) * BD;
  endfunction

  // Expected line level t cycles after the start edge, from the frame layout.
  function automatic logic model_tx(input int i, input logic [7:0] d, input int t);
    int slot = t / BD;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    if (par_cfg(i) != 0 && slot == 9) begin
      int ones = 0;
      for (int b = 0; b < 8; b++) ones += int'(d[b]);
      return (par_cfg(i) == 1) ? logic'(ones % 2) : logic'(1 - ones % 2);
    end
    return 1'b1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns 1ns after the edge that samples the write.
  task automatic push_byte(input int i, input logic [7:0] d);
    wr_data[i] = d;
    wr_en[i]   = 1'b1;
    @(posedge clk); #1;
    wr_en[i]   = 1'b0;
  endtask

  // Entered just before the negedge of frame cycle 0; ends on the idle-gap negedge.
  task automatic check_frame(input int i, input logic [7:0] d, input int drop_at,
                             output int errs, output int busy_cnt, output logic slot9);
    int len = frame_len(i);
    errs = 0; busy_cnt = 0; slot9 = 1'b0;
    for (int t = 0; t <= len; t++) begin
      @(negedge clk);
      if (tx[i] !== model_tx(i, d, t)) errs++;
      if (busy[i] !== (t < len)) errs++;
      if (busy[i] === 1'b1) busy_cnt++;
      if (t == 9 * BD + BD / 2) slot9 = tx[i];
      if (t == drop_at) cts[i] = 1'b0;
    end
  endtask

  task automatic frame_ok(input int i, input logic [7:0] d, input int drop_at, input string name);
    int e, bc;
    logic s9;
    check_frame(i, d, drop_at, e, bc, s9);
    check(name, e, 0);
  endtask

  // Called at posedge+1; ends just before the first start-bit negedge.
  task automatic raise_cts(input int i);
    cts[i] = 1'b1;
    repeat (3) @(negedge clk);
    check("cts_sync_delay", int'(tx[i]), 1);
  endtask

  task automatic idle_for(input int i, input int n, input string name);
    int e = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx[i] !== 1'b1 || busy[i] !== 1'b0) e++;
    end
    check(name, e, 0);
  endtask

  typedef struct {
    int         inst;
    logic [7:0] data;
    int         exp_busy;
    logic       exp_slot9;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int e, bc, cnt;
    logic s9;

    vecs[0] = '{inst: 0, data: 8'h55, exp_busy: 160, exp_slot9: 1'b1};
    vecs[1] = '{inst: 1, data: 8'h07, exp_busy: 176, exp_slot9: 1'b1};
    vecs[2] = '{inst: 2, data: 8'h07, exp_busy: 192, exp_slot9: 1'b0};
    vecs[3] = '{inst: 3, data: 8'hC3, exp_busy: 160, exp_slot9: 1'b1};

    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      wr_en[i] = 1'b0; wr_data[i] = 8'h00; cts[i] = 1'b1;
    end
    repeat (3) @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      check("rst_tx", int'(tx[i]), 1);
      check("rst_busy", int'(busy[i]), 0);
      check("rst_full", int'(full[i]), 0);
      check("rst_empty", int'(empty[i]), 1);
      check("rst_level", lvl(i), 0);
      check("rst_overflow", int'(overflow[i]), 0);
    end
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;

    // Single frames per configuration.
    foreach (vecs[v]) begin
      push_byte(vecs[v].inst, vecs[v].data);
      @(negedge clk);
      check("latency_pre", int'(tx[vecs[v].inst]), 1);
      check_frame(vecs[v].inst, vecs[v].data, -1, e, bc, s9);
      check("frame_wave", e, 0);
      check("frame_busy_len", bc, vecs[v].exp_busy);
      check("frame_slot9", int'(s9), int'(vecs[v].exp_slot9));
      @(posedge clk); #1;
    end

    // Flow-control hold and release.
    cts[0] = 1'b0;
    repeat (4) @(posedge clk); #1;
    push_byte(0, 8'h11);
    push_byte(0, 8'h22);
    push_byte(0, 8'h33);
    idle_for(0, 30, "hold_idle");
    check("hold_level", lvl(0), 3);
    @(posedge clk); #1;
    raise_cts(0);
    frame_ok(0, 8'h11, -1, "flow_frame0");
    frame_ok(0, 8'h22, -1, "flow_frame1");
    frame_ok(0, 8'h33, -1, "flow_frame2");
    check("flow_level_end", lvl(0), 0);
    @(posedge clk); #1;

    // CTS dropped during the data bits.
    cts[0] = 1'b0;
    repeat (4) @(posedge clk); #1;
    push_byte(0, 8'hA5);
    push_byte(0, 8'h3C);
    @(posedge clk); #1;
    raise_cts(0);
    frame_ok(0, 8'hA5, 4 * BD + 3, "drop_frame");
    idle_for(0, 40, "drop_hold");
    check("drop_level", lvl(0), 1);
    @(posedge clk); #1;
    raise_cts(0);
    frame_ok(0, 8'h3C, -1, "drop_resume");
    @(posedge clk); #1;

    // Full / overflow on the depth-4 instance.
    cts[3] = 1'b0;
    repeat (4) @(posedge clk); #1;
    for (int n = 1; n <= 5; n++) begin
      wr_data[3] = 8'(8'hA0 + n);
      wr_en[3]   = 1'b1;
      @(posedge clk); #1;
      check("ovf_level", lvl(3), (n < 4) ? n : 4);
      check("ovf_full", int'(full[3]), (n >= 4) ? 1 : 0);
      check("ovf_pulse", int'(overflow[3]), (n == 5) ? 1 : 0);
    end
    wr_en[3] = 1'b0;
    @(posedge clk); #1;
    check("ovf_pulse_end", int'(overflow[3]), 0);
    check("ovf_level_hold", lvl(3), 4);
    raise_cts(3);
    for (int n = 1; n <= 4; n++) frame_ok(3, 8'(8'hA0 + n), -1, "ovf_frame");
    idle_for(3, 200, "ovf_dropped_never_sent");
    check("ovf_empty_end", int'(empty[3]), 1);
    @(posedge clk); #1;

    // Reset during data bit 3.
    push_byte(0, 8'h5A);
    push_byte(0, 8'h99);
    repeat (68) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_tx", int'(tx[0]), 1);
    check("midrst_busy", int'(busy[0]), 0);
    check("midrst_empty", int'(empty[0]), 1);
    check("midrst_level", lvl(0), 0);
    rst = 1'b0;
    idle_for(0, 300, "midrst_no_frames");
    @(posedge clk); #1;

    // Random traffic with random CTS gaps, decoded from the line.
    cts[0] = 1'b1;
    exp_q.delete();
    fork
      begin
        for (int n = 0; n < NR; n++) begin
          logic [7:0] d;
          repeat ($urandom_range(0, 120)) @(posedge clk);
          #1;
          if ($urandom_range(0, 3) == 0) begin
            cts[0] = 1'b0;
            repeat ($urandom_range(10, 300)) @(posedge clk);
            #1;
            cts[0] = 1'b1;
          end
          d = 8'($urandom);
          if (full[0] === 1'b0) exp_q.push_back(d);
          push_byte(0, d);
        end
      end
      begin
        for (int n = 0; n < NR; n++) begin
          logic [7:0] got;
          logic       s_bit, p_bit;
          int         w = 0;
          do begin
            @(negedge clk);
            w++;
          end while (tx[0] !== 1'b0 && w < 20000);
          if (w >= 20000) begin
            check("rand_start_timeout", w, 0);
            break;
          end
          repeat (BD / 2) @(negedge clk);
          s_bit = tx[0];
          for (int b = 0; b < 8; b++) begin
            repeat (BD) @(negedge clk);
            got[b] = tx[0];
          end
          repeat (BD) @(negedge clk);
          p_bit = tx[0];
          repeat (BD / 2) @(negedge clk);
          if (exp_q.size() == 0) check("rand_unexpected_frame", int'(got), -1);
          else check("rand_frame", {22'd0, s_bit, p_bit, got}, {22'd0, 2'b01, exp_q.pop_front()});
        end
      end
    join
    cnt = 0;
    while ((empty[0] !== 1'b1 || busy[0] !== 1'b0) && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    check("rand_drain_timeout", (cnt < 5000) ? 1 : 0, 1);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
